// File: rtl/rast_pkg.sv
// rtl/rast_pkg.sv - shared types, constants and helpers for the rasterizer fill datapath
package rast_pkg;
    localparam int CMD_X_W      = 10;
    localparam int CMD_Y_W      = 9;
    localparam int CMD_COLOR_W  = 24;
    localparam int BURSTCOUNT_W = 8;
    localparam int PIXEL_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLIP,
        ST_ROW,
        ST_BURST,
        ST_NEXT_ROW,
        ST_FINISH
    } fill_state_e;

    function automatic int ppw_of(input int data_width);
        return data_width / PIXEL_W;
    endfunction

    // Frame buffer pixels are stored as {pad, B, G, R} with R in the low byte.
    function automatic logic [PIXEL_W-1:0] pack_pixel(input logic [CMD_COLOR_W-1:0] color);
        return {8'h00, color[7:0], color[15:8], color[23:16]};
    endfunction
endpackage

// File: rtl/rast_lane_mask.sv
// rtl/rast_lane_mask.sv - byteenable for a row-edge word: lanes >= offset (first) or <= offset (last)
module rast_lane_mask
    import rast_pkg::*;
#(
    parameter int PPW = 2
) (
    input  logic [$clog2(PPW)-1:0] lane_i,
    input  logic                   first_i,
    output logic [PPW*4-1:0]       be_o
);
    localparam int LANE_W = $clog2(PPW);

    always_comb begin
        be_o = '0;
        for (int i = 0; i < PPW; i++) begin
            if (first_i ? (LANE_W'(i) >= lane_i) : (LANE_W'(i) <= lane_i)) begin
                be_o[i*4 +: 4] = 4'hF;
            end
        end
    end
endmodule

// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - clipped solid rectangle fill over a bursting memory write master
module rect_fill_engine
    import rast_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 29,
    parameter int FB_WIDTH   = 800,
    parameter int FB_HEIGHT  = 480,
    parameter int MAX_BURST  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CMD_X_W-1:0]      cmd_x0,
    input  logic [CMD_X_W-1:0]      cmd_x1,
    input  logic [CMD_Y_W-1:0]      cmd_y0,
    input  logic [CMD_Y_W-1:0]      cmd_y1,
    input  logic [CMD_COLOR_W-1:0]  cmd_color,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [BURSTCOUNT_W-1:0] burstcount,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    waitrequest
);
    localparam int PPW       = ppw_of(DATA_WIDTH);
    localparam int LANE_W    = $clog2(PPW);
    localparam int ROW_WORDS = FB_WIDTH / PPW;
    localparam int BE_W      = DATA_WIDTH / 8;

    typedef logic [CMD_X_W-1:0]      word_t;
    typedef logic [CMD_X_W:0]        span_t;
    typedef logic [CMD_Y_W-1:0]      row_t;
    typedef logic [BURSTCOUNT_W-1:0] bc_t;
    typedef logic [ADDR_WIDTH-1:0]   addr_t;
    typedef logic [BE_W-1:0]         be_t;

    fill_state_e state_q, state_d;
    word_t       x0_q, x1_q, cur_w_q, cur_w_d;
    row_t        y0_q, y1_q, y_q, y_d;
    logic [CMD_COLOR_W-1:0] color_q;
    addr_t       base_q, row_base_q, row_base_d, addr_q, addr_d;
    bc_t         bcount_q, bcount_d, beats_q, beats_d;
    logic        write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    be_t         be_q, be_d, mask_first, mask_last;

    word_t x1_clamp, first_w, last_w, next_w, sb_w;
    row_t  y1_clamp;
    addr_t row0_base, sb_base;
    logic  clip_empty, start_burst;
    bc_t   sb_len;

    assign x1_clamp   = (x1_q > word_t'(FB_WIDTH - 1)) ? word_t'(FB_WIDTH - 1) : x1_q;
    assign y1_clamp   = (y1_q > row_t'(FB_HEIGHT - 1)) ? row_t'(FB_HEIGHT - 1) : y1_q;
    assign first_w    = x0_q >> LANE_W;
    assign last_w     = x1_clamp >> LANE_W;
    assign clip_empty = (x0_q > x1_clamp) || (y0_q > y1_clamp);
    assign row0_base  = base_q + addr_t'(y0_q) * addr_t'(ROW_WORDS);
    assign next_w     = cur_w_q + word_t'(1);

    rast_lane_mask #(.PPW(PPW)) u_mask_first (
        .lane_i  (x0_q[LANE_W-1:0]),
        .first_i (1'b1),
        .be_o    (mask_first)
    );

    rast_lane_mask #(.PPW(PPW)) u_mask_last (
        .lane_i  (x1_clamp[LANE_W-1:0]),
        .first_i (1'b0),
        .be_o    (mask_last)
    );

    function automatic be_t word_be(input word_t w, input word_t fw, input word_t lw,
                                    input be_t mf, input be_t ml);
        be_t be;
        be = '1;
        if (w == fw) be = be & mf;
        if (w == lw) be = be & ml;
        return be;
    endfunction

    // Bursts are cut at the row end so a burst never wraps into the next row.
    function automatic bc_t burst_len(input word_t w, input word_t lw);
        span_t rem;
        rem = span_t'(lw) - span_t'(w) + span_t'(1);
        return (rem > span_t'(MAX_BURST)) ? bc_t'(MAX_BURST) : bc_t'(rem);
    endfunction

    always_comb begin
        state_d     = state_q;
        row_base_d  = row_base_q;
        y_d         = y_q;
        cur_w_d     = cur_w_q;
        addr_d      = addr_q;
        bcount_d    = bcount_q;
        beats_d     = beats_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        start_burst = 1'b0;
        sb_base     = row_base_q;
        sb_w        = cur_w_q;
        sb_len      = burst_len(sb_w, last_w);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_CLIP;
            end
            // The first burst is set up directly from CLIP so the first beat lands at T+2.
            ST_CLIP: begin
                if (clip_empty) begin
                    state_d = ST_FINISH;
                end else begin
                    row_base_d  = row0_base;
                    y_d         = y0_q;
                    cur_w_d     = first_w;
                    wdata_d     = {PPW{pack_pixel(color_q)}};
                    start_burst = 1'b1;
                    sb_base     = row0_base;
                    sb_w        = first_w;
                    sb_len      = burst_len(first_w, last_w);
                end
            end
            ST_ROW: begin
                start_burst = 1'b1;
            end
            ST_BURST: begin
                if (!waitrequest) begin
                    cur_w_d = next_w;
                    beats_d = beats_q - bc_t'(1);
                    be_d    = word_be(next_w, first_w, last_w, mask_first, mask_last);
                    if (beats_q == bc_t'(1)) begin
                        write_d = 1'b0;
                        state_d = (next_w > last_w) ? ST_NEXT_ROW : ST_ROW;
                    end
                end
            end
            ST_NEXT_ROW: begin
                if (y_q == y1_clamp) begin
                    state_d = ST_FINISH;
                end else begin
                    y_d        = y_q + row_t'(1);
                    row_base_d = row_base_q + addr_t'(ROW_WORDS);
                    cur_w_d    = first_w;
                    state_d    = ST_ROW;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_burst) begin
            addr_d   = sb_base + addr_t'(sb_w);
            bcount_d = sb_len;
            beats_d  = sb_len;
            write_d  = 1'b1;
            be_d     = word_be(sb_w, first_w, last_w, mask_first, mask_last);
            state_d  = ST_BURST;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            color_q    <= '0;
            base_q     <= '0;
            row_base_q <= '0;
            y_q        <= '0;
            cur_w_q    <= '0;
            addr_q     <= '0;
            bcount_q   <= bc_t'(1);
            beats_q    <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            y_q        <= y_d;
            cur_w_q    <= cur_w_d;
            addr_q     <= addr_d;
            bcount_q   <= bcount_d;
            beats_q    <= beats_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if (state_q == ST_IDLE && cmd_valid) begin
                x0_q    <= cmd_x0;
                x1_q    <= cmd_x1;
                y0_q    <= cmd_y0;
                y1_q    <= cmd_y1;
                color_q <= cmd_color;
                base_q  <= cmd_base;
            end
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign address    = addr_q;
    assign burstcount = bcount_q;
    assign write      = write_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb/tb_rect_fill_engine.sv - table-driven bench for rect_fill_engine (64-bit, MAX_BURST=4)
module tb_rect_fill_engine;
    localparam int DW  = 64;
    localparam int AW  = 29;
    localparam int BEW = DW / 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [9:0]     cmd_x0 = '0, cmd_x1 = '0;
    logic [8:0]     cmd_y0 = '0, cmd_y1 = '0;
    logic [23:0]    cmd_color = '0;
    logic [AW-1:0]  cmd_base = 29'h1000;
    logic           busy, done, write;
    logic [AW-1:0]  address;
    logic [7:0]     burstcount;
    logic [DW-1:0]  writedata;
    logic [BEW-1:0] byteenable;
    logic           waitrequest = 1'b0;

    rect_fill_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FB_WIDTH   (800),
        .FB_HEIGHT  (480),
        .MAX_BURST  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_x1      (cmd_x1),
        .cmd_y0      (cmd_y0),
        .cmd_y1      (cmd_y1),
        .cmd_color   (cmd_color),
        .cmd_base    (cmd_base),
        .busy        (busy),
        .done        (done),
        .address     (address),
        .burstcount  (burstcount),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  x0, x1;
        logic [8:0]  y0, y1;
        logic [23:0] color;
        logic [63:0] wd;
        int          nbeats;
        int          done_off;
        int          stall_at;
    } cmd_t;

    typedef struct {
        int          off;
        logic [28:0] addr;
        logic [7:0]  bc;
        logic [7:0]  be;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [7:0]    bc;
        logic [DW-1:0] wd;
        logic [BEW-1:0] be;
    } rec_t;

    cmd_t  cmds[$];
    beat_t exp_beats[$];
    rec_t  beats[$];
    rec_t  stalls[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_acc = 0;
    int stall_at = -1;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        waitrequest = (stall_at >= 0) && (cyc - t_acc >= stall_at) && (cyc - t_acc < stall_at + 3);
    end

    always @(negedge clock) begin
        rec_t r;
        r.cyc  = cyc;
        r.addr = address;
        r.bc   = burstcount;
        r.wd   = writedata;
        r.be   = byteenable;
        if (!reset && write) begin
            if (waitrequest) stalls.push_back(r);
            else             beats.push_back(r);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_beat(input int off, input int addr, input int bc, input int be);
        exp_beats.push_back(beat_t'{off, 29'(addr), 8'(bc), 8'(be)});
    endtask

    task automatic run_cmd(input int idx);
        cmd_t c;
        int   first;
        int   k;
        int   t_done;
        c = cmds[idx];
        first = 0;
        for (int i = 0; i < idx; i++) first += cmds[i].nbeats;
        beats.delete();
        stalls.delete();

        @(posedge clock); #1;
        cmd_x0 = c.x0; cmd_x1 = c.x1; cmd_y0 = c.y0; cmd_y1 = c.y1;
        cmd_color = c.color; cmd_valid = 1'b1;
        @(negedge clock);
        chk($sformatf("c%0d_ready_idle", idx), 64'(cmd_ready), 64'd1);
        t_acc = cyc;
        stall_at = c.stall_at;

        // Fields change and valid stays high while the engine is in CLIP: must be ignored.
        @(posedge clock); #1;
        cmd_x0 = 10'd0; cmd_x1 = 10'd1023; cmd_y0 = 9'd0; cmd_y1 = 9'd511; cmd_color = 24'hFFFFFF;
        @(negedge clock);
        chk($sformatf("c%0d_ready_busy", idx), 64'(cmd_ready), 64'd0);
        chk($sformatf("c%0d_busy", idx), 64'(busy), 64'd1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;

        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!done && k < 200);
        t_done = cyc;
        chk($sformatf("c%0d_done_seen", idx), 64'(done), 64'd1);
        chk($sformatf("c%0d_done_cycle", idx), 64'(t_done - t_acc), 64'(c.done_off));
        @(negedge clock);
        chk($sformatf("c%0d_ready_after", idx), 64'(cmd_ready), 64'd1);
        chk($sformatf("c%0d_busy_after", idx), 64'(busy), 64'd0);
        stall_at = -1;

        chk($sformatf("c%0d_beat_count", idx), 64'(beats.size()), 64'(c.nbeats));
        for (int i = 0; i < c.nbeats && i < beats.size(); i++) begin
            beat_t e;
            e = exp_beats[first + i];
            chk($sformatf("c%0d_b%0d_addr", idx, i), 64'(beats[i].addr), 64'(e.addr));
            chk($sformatf("c%0d_b%0d_bc", idx, i), 64'(beats[i].bc), 64'(e.bc));
            chk($sformatf("c%0d_b%0d_wd", idx, i), beats[i].wd, c.wd);
            chk($sformatf("c%0d_b%0d_be", idx, i), 64'(beats[i].be), 64'(e.be));
            chk($sformatf("c%0d_b%0d_cycle", idx, i), 64'(beats[i].cyc - t_acc), 64'(e.off));
        end

        if (c.stall_at >= 0) begin
            chk($sformatf("c%0d_stall_cycles", idx), 64'(stalls.size()), 64'd3);
            for (int i = 0; i < stalls.size(); i++) begin
                chk($sformatf("c%0d_s%0d_addr", idx, i), 64'(stalls[i].addr), 64'(exp_beats[first+1].addr));
                chk($sformatf("c%0d_s%0d_bc", idx, i), 64'(stalls[i].bc), 64'(exp_beats[first+1].bc));
                chk($sformatf("c%0d_s%0d_wd", idx, i), stalls[i].wd, c.wd);
                chk($sformatf("c%0d_s%0d_be", idx, i), 64'(stalls[i].be), 64'(exp_beats[first+1].be));
            end
        end
    endtask

    initial begin
        cmds.push_back(cmd_t'{10'd0,   10'd19,  9'd0,   9'd0,   24'h112233, 64'h0033221100332211, 10, 15, -1});
        for (int i = 0; i < 4; i++) add_beat(2 + i, 'h1000, 4, 'hFF);
        for (int i = 0; i < 4; i++) add_beat(7 + i, 'h1004, 4, 'hFF);
        for (int i = 0; i < 2; i++) add_beat(12 + i, 'h1008, 2, 'hFF);

        cmds.push_back(cmd_t'{10'd1,   10'd4,   9'd2,   9'd2,   24'hABCDEF, 64'h00EFCDAB00EFCDAB, 3, 6, -1});
        add_beat(2, 'h1320, 3, 'hF0);
        add_beat(3, 'h1320, 3, 'hFF);
        add_beat(4, 'h1320, 3, 'h0F);

        cmds.push_back(cmd_t'{10'd3,   10'd3,   9'd0,   9'd0,   24'h010203, 64'h0003020100030201, 1, 4, -1});
        add_beat(2, 'h1001, 1, 'hF0);

        cmds.push_back(cmd_t'{10'd798, 10'd900, 9'd478, 9'd511, 24'hFF0080, 64'h008000FF008000FF, 2, 7, -1});
        add_beat(2, 'h1000 + 191599, 1, 'hFF);
        add_beat(5, 'h1000 + 191999, 1, 'hFF);

        cmds.push_back(cmd_t'{10'd900, 10'd950, 9'd0,   9'd0,   24'h123456, 64'h0, 0, 2, -1});
        cmds.push_back(cmd_t'{10'd5,   10'd2,   9'd0,   9'd0,   24'h123456, 64'h0, 0, 2, -1});

        cmds.push_back(cmd_t'{10'd3,   10'd10,  9'd10,  9'd11,  24'hC0FFEE, 64'h00EEFFC000EEFFC0, 10, 17, -1});
        add_beat(2, 'h1FA1, 4, 'hF0);
        for (int i = 0; i < 3; i++) add_beat(3 + i, 'h1FA1, 4, 'hFF);
        add_beat(7, 'h1FA5, 1, 'h0F);
        add_beat(10, 'h2131, 4, 'hF0);
        for (int i = 0; i < 3; i++) add_beat(11 + i, 'h2131, 4, 'hFF);
        add_beat(15, 'h2135, 1, 'h0F);

        cmds.push_back(cmd_t'{10'd0,   10'd7,   9'd0,   9'd0,   24'h445566, 64'h0066554400665544, 4, 10, 3});
        add_beat(2, 'h1000, 4, 'hFF);
        add_beat(6, 'h1000, 4, 'hFF);
        add_beat(7, 'h1000, 4, 'hFF);
        add_beat(8, 'h1000, 4, 'hFF);

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_burstcount", 64'(burstcount), 64'd1);
        chk("rst_writedata", writedata, 64'd0);
        chk("rst_byteenable", 64'(byteenable), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < cmds.size(); i++) run_cmd(i);

        @(posedge clock); #1;
        cmd_x0 = 10'd0; cmd_x1 = 10'd19; cmd_y0 = 9'd0; cmd_y1 = 9'd0;
        cmd_color = 24'h112233; cmd_valid = 1'b1;
        @(negedge clock);
        chk("midrst_accept", 64'(cmd_ready), 64'd1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("midrst_write_before", 64'(write), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_write", 64'(write), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_address", 64'(address), 64'd0);
        chk("midrst_burstcount", 64'(burstcount), 64'd1);
        chk("midrst_byteenable", 64'(byteenable), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_cmd(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
